// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO with a valid/ready write port, runtime parity, 5..9 data bits.
// Latency: a word accepted on edge E into an empty, idle transmitter drives the start bit from edge E+1.
// Backpressure: tx_ready is low only while the FIFO holds FIFO_DEPTH words (registered state, no pop path).
// Optional feature macro UART_TX_BREAK_EN adds tx_break (line held low between frames while asserted).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              tx_data_in,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic                              parity_en,
    input  logic                              even_odd,
`ifdef UART_TX_BREAK_EN
    input  logic                              tx_break,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              busy,
    output logic                              serial_out
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BRK    = 3'd5;   // line held low
    localparam logic [2:0] ST_MARK   = 3'd6;   // one bit time of idle-high after a break
`endif

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic                 push, pop;

    // Frame state
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ser_q, ser_d;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign tx_ready   = (level_q != LVL_FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_level = level_q;
    assign busy       = (state_q != ST_IDLE) || (level_q != '0);
    assign serial_out = ser_q;
    assign bit_end    = (cnt_q == BIT_LAST);
    assign head       = mem_q[rd_ptr_q];

    // FIFO data array; contents need no reset since the pointers define validity
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the level
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Frame sequencer: next state, baud/bit counters, and the registered line value
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        ser_d     = ser_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ser_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    state_d = ST_BRK;
                    ser_d   = 1'b0;
                end else
`endif
                if (level_q != '0) pop = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    ser_d   = shift_q[0];
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        ser_d   = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        ser_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    ser_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    // Back-to-back frames: go straight to the next start bit
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ser_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BRK: begin
                if (!tx_break) begin
                    state_d = ST_MARK;
                    ser_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_MARK: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                ser_d   = 1'b1;
            end
        endcase
        // A pop loads the word and freezes the parity settings for the whole frame
        if (pop) begin
            state_d   = ST_START;
            ser_d     = 1'b0;
            cnt_d     = '0;
            shift_d   = head;
            par_en_d  = parity_en;
            par_bit_d = even_odd ? ~^head : ^head;
        end
    end

    // Frame state registers; reset aborts any frame and returns the line high
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            ser_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            ser_q     <= ser_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a frame scoreboard.
// Two instances: 8N/8P1 with 1 stop bit, and 5 data bits with 2 stop bits; 4 clocks per bit.
// Expected line-level frames are built from the pushed words and compared cycle by cycle.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data0 = '0;
    logic       vld0 = 1'b0, rdy0, pe0 = 1'b0, eo0 = 1'b0, busy0, ser0;
    logic [2:0] lvl0;
    logic [4:0] data1 = '0;
    logic       vld1 = 1'b0, rdy1, pe1 = 1'b0, eo1 = 1'b0, busy1, ser1;
    logic [2:0] lvl1;
`ifdef UART_TX_BREAK_EN
    logic       brk0 = 1'b0;
    logic       brk1 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .sys_clk(clk), .rst(rst), .tx_data_in(data0), .tx_valid(vld0), .tx_ready(rdy0),
        .parity_en(pe0), .even_odd(eo0),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk0),
`endif
        .fifo_level(lvl0), .busy(busy0), .serial_out(ser0)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .sys_clk(clk), .rst(rst), .tx_data_in(data1), .tx_valid(vld1), .tx_ready(rdy1),
        .parity_en(pe1), .even_odd(eo1),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk1),
`endif
        .fifo_level(lvl1), .busy(busy1), .serial_out(ser1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s
    function automatic frame_t mk(input logic [8:0] d, input int nd, input bit pe,
                                  input bit odd, input int ns);
        frame_t f;
        int     k;
        logic   p;
        f.bits = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = odd ? ~p : p;
            k++;
        end
        for (int i = 0; i < ns; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    function automatic logic line(input bit sel);
        if (sel) return ser1;
        return ser0;
    endfunction

    // Wait for a start bit, then compare every cycle of the frame against the scoreboard head
    task automatic expect_frame(input bit sel, input int exp_wait, input string tag, output int waited);
        frame_t     f;
        logic [3:0] s;
        int         n;
        n = 0;
        while (line(sel) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        chk($sformatf("%s_start_seen", tag), 32'(n < 400), 32'd1);
        if (n >= 400) return;
        if (exp_wait >= 0) chk($sformatf("%s_gap", tag), n, exp_wait);
        if (sel) begin
            chk($sformatf("%s_sb_nonempty", tag), 32'(q1.size() != 0), 32'd1);
            if (q1.size() == 0) return;
            f = q1.pop_front();
        end else begin
            chk($sformatf("%s_sb_nonempty", tag), 32'(q0.size() != 0), 32'd1);
            if (q0.size() == 0) return;
            f = q0.pop_front();
        end
        for (int b = 0; b < f.len; b++) begin
            for (int c = 0; c < 4; c++) begin
                s[c] = line(sel);
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(s), 32'({4{f.bits[b]}}));
        end
    endtask

    task automatic push0(input logic [7:0] d);
        q0.push_back(mk({1'b0, d}, 8, pe0, eo0, 1));
        data0 = d;
        vld0  = 1'b1;
        @(negedge clk);
        vld0  = 1'b0;
    endtask

    task automatic push1(input logic [4:0] d);
        q1.push_back(mk({4'b0, d}, 5, pe1, eo1, 2));
        data1 = d;
        vld1  = 1'b1;
        @(negedge clk);
        vld1  = 1'b0;
    endtask

    initial begin
        int         w, k, cyc, lows;
        logic       acc;
        bit         seen_full;
        logic [7:0] wl [6];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_line", ser0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_level", lvl0, 0);
        chk("rst_line_u1", ser1, 1);
        rst = 1'b0;
        @(negedge clk);

        // 8'hCC with odd parity; parity settings changed mid-frame must not matter
        pe0 = 1'b1; eo0 = 1'b1;
        push0(8'hCC);
        chk("lat_line_before", ser0, 1);
        chk("lat_level", lvl0, 1);
        chk("lat_busy", busy0, 1);
        fork
            expect_frame(0, 1, "t2", w);
            begin
                repeat (12) @(negedge clk);
                pe0 = 1'b0; eo0 = 1'b0;
            end
        join
        chk("t2_busy_end", busy0, 0);

        // No parity, then even parity
        pe0 = 1'b0;
        push0(8'hCC);
        expect_frame(0, 1, "t3a", w);
        chk("t3a_busy_end", busy0, 0);
        pe0 = 1'b1; eo0 = 1'b0;
        push0(8'hCC);
        expect_frame(0, 1, "t3b", w);
        chk("t3b_busy_end", busy0, 0);

        // Six words with tx_valid held: backpressure at full, contiguous frames in order
        pe0 = 1'b0;
        wl = '{8'h01, 8'h5A, 8'hF0, 8'h3C, 8'h81, 8'hE7};
        fork
            begin
                k = 0; cyc = 0; seen_full = 1'b0;
                while (k < 6 && cyc < 600) begin
                    data0 = wl[k];
                    vld0  = 1'b1;
                    acc   = rdy0;
                    @(negedge clk);
                    cyc++;
                    if (acc) begin
                        q0.push_back(mk({1'b0, wl[k]}, 8, 1'b0, 1'b0, 1));
                        k++;
                    end
                    if (k == 5 && !seen_full) begin
                        seen_full = 1'b1;
                        chk("t4_level_full", lvl0, 4);
                        chk("t4_ready_full", rdy0, 0);
                    end
                end
                vld0 = 1'b0;
                chk("t4_all_accepted", k, 6);
            end
            begin
                expect_frame(0, -1, "t4f0", w);
                for (int i = 1; i < 6; i++) expect_frame(0, 0, $sformatf("t4f%0d", i), w);
            end
        join
        chk("t4_busy_end", busy0, 0);
        chk("t4_level_end", lvl0, 0);
        chk("t4_sb_drained", q0.size(), 0);

        // 5 data bits, 2 stop bits, parity off then even parity
        push1(5'h15);
        expect_frame(1, 1, "t5a", w);
        chk("t5a_busy_end", busy1, 0);
        pe1 = 1'b1; eo1 = 1'b0;
        push1(5'h15);
        expect_frame(1, 1, "t5b", w);
        chk("t5b_busy_end", busy1, 0);

        // Reset during a low data bit with a second word queued
        pe0 = 1'b0;
        data0 = 8'hA5;
        vld0 = 1'b1;
        @(negedge clk);
        data0 = 8'h3C;
        @(negedge clk);
        vld0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("t1_pre_line", ser0, 0);
        rst = 1'b1;
        #1;
        chk("t1_line", ser0, 1);
        chk("t1_busy", busy0, 0);
        chk("t1_ready", rdy0, 1);
        chk("t1_level", lvl0, 0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser0 !== 1'b1) lows++;
        end
        chk("t1_idle_after", lows, 0);
        chk("t1_busy_after", busy0, 0);

`ifdef UART_TX_BREAK_EN
        // Break requested mid-frame: frame completes, then line low; held push waits
        push0(8'h81);
        fork
            expect_frame(0, 1, "t6a", w);
            begin
                repeat (10) @(negedge clk);
                brk0 = 1'b1;
            end
        join
        @(negedge clk);
        chk("t6_break_low", ser0, 0);
        chk("t6_break_busy", busy0, 1);
        push0(8'h42);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (ser0 === 1'b0) lows++;
        end
        chk("t6_break_held", lows, 30);
        chk("t6_break_level", lvl0, 1);
        brk0 = 1'b0;
        @(negedge clk);
        expect_frame(0, -1, "t6b", w);
        chk("t6_mark_len", 32'(w >= 4), 32'd1);
        chk("t6_busy_end", busy0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
